alu_req_scheduler: RTL and testbench

Arbitrated front-end for the 256-bit SIMD ALU (32 independent 8-bit lanes; modes add/and/or/xor). It shares one ALU instance among NUM_REQ requesters using round-robin, registers the winning operands and mode into the ALU inputs, and captures the lane-wise result. The result is returned on a single valid/ready response channel tagged with the requester index. It sits between the issue logic of the vector units and the ALU datapath.

---
 rtl/alu_req_scheduler.sv | 144 ++++++++++++++
 tb/tb_alu_req_scheduler.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_scheduler.sv
// Round-robin front-end that shares one external SIMD ALU among NUM_REQ requesters
// and returns each lane-wise result on a tagged valid/ready response channel.
module alu_req_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 256,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_op0,
  input  logic [NUM_REQ*DATA_W-1:0] req_op1,
  input  logic [NUM_REQ*2-1:0]      req_mode,
  output logic [DATA_W-1:0]         alu_op0,
  output logic [DATA_W-1:0]         alu_op1,
  output logic [1:0]                alu_mode,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic [15:0]               ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_found;
  logic              grant_fire;
  logic              rsp_fire;
  logic [DATA_W-1:0] sel_op0;
  logic [DATA_W-1:0] sel_op1;
  logic [1:0]        sel_mode;
  int                cand;
  logic [ID_W-1:0]   cand_idx;

  // Search upward from the requester after the last winner; first valid one wins.
  // NOTE: every signal assigned in an always_comb gets a default before any branch,
  // otherwise paths that skip the assignment infer a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_grant) + k) % NUM_REQ;
      cand_idx = ID_W'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Operand/mode mux for the requester being granted.
  always_comb begin
    sel_op0  = '0;
    sel_op1  = '0;
    sel_mode = 2'b00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_op0  = req_op0[i*DATA_W +: DATA_W];
        sel_op1  = req_op1[i*DATA_W +: DATA_W];
        sel_mode = req_mode[2*i +: 2];
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    grant_fire = 1'b0;
    rsp_fire   = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_found) begin
          grant_fire           = 1'b1;
          req_ready[grant_idx] = !rst;
          state_next           = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_fire   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A reset in EXEC or RESP drops the in-flight op without producing its response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      alu_op0    <= '0;
      alu_op1    <= '0;
      alu_mode   <= 2'b00;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      ops_done   <= 16'd0;
    end else begin
      if (grant_fire) begin
        alu_op0    <= sel_op0;
        alu_op1    <= sel_op1;
        alu_mode   <= sel_mode;
        rsp_id     <= grant_idx;
        last_grant <= grant_idx;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_result;
        rsp_valid <= 1'b1;
      end
      if (rsp_fire) begin
        rsp_valid <= 1'b0;
        ops_done  <= ops_done + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Self-checking bench for alu_req_scheduler: directed vector table, multi-cycle corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_alu_req_scheduler;

  localparam int NR = 4;
  localparam int DW = 256;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_op0;
  logic [NR*DW-1:0]  req_op1;
  logic [NR*2-1:0]   req_mode;
  logic [DW-1:0]     alu_op0;
  logic [DW-1:0]     alu_op1;
  logic [1:0]        alu_mode;
  logic [DW-1:0]     alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              busy;
  logic [15:0]       ops_done;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  alu_req_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op0    (req_op0),
    .req_op1    (req_op1),
    .req_mode   (req_mode),
    .alu_op0    (alu_op0),
    .alu_op1    (alu_op1),
    .alu_mode   (alu_mode),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  // Lane-wise SIMD ALU behaviour: 8-bit lanes, add wraps per lane.
  function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [1:0] m);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < DW/8; l++) begin
      case (m)
        2'b00:   r[l*8 +: 8] = 8'(a[l*8 +: 8] + b[l*8 +: 8]);
        2'b01:   r[l*8 +: 8] = a[l*8 +: 8] & b[l*8 +: 8];
        2'b10:   r[l*8 +: 8] = a[l*8 +: 8] | b[l*8 +: 8];
        default: r[l*8 +: 8] = a[l*8 +: 8] ^ b[l*8 +: 8];
      endcase
    end
    return r;
  endfunction

  assign alu_result = alu_fn(alu_op0, alu_op1, alu_mode);

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int winner(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  // ---------------- reference model (transaction timeline) ----------------
  int            m_last;
  bit            m_busy;
  int            m_age;      // 1 = ALU evaluating, 2 = response offered
  int            m_id;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_a0;
  logic [DW-1:0] m_a1;
  logic [1:0]    m_mode;
  logic [15:0]   m_ops;

  always @(posedge clk or posedge rst) begin : model
    int w;
    if (rst) begin
      m_last = NR - 1; m_busy = 1'b0; m_age = 0; m_id = 0;
      m_data = '0; m_a0 = '0; m_a1 = '0; m_mode = 2'b00; m_ops = 16'd0;
    end else if (!m_busy) begin
      w = winner(req_valid, m_last);
      if (w >= 0) begin
        m_busy = 1'b1; m_age = 1; m_id = w; m_last = w;
        m_a0   = req_op0[w*DW +: DW];
        m_a1   = req_op1[w*DW +: DW];
        m_mode = req_mode[2*w +: 2];
        m_data = alu_fn(m_a0, m_a1, m_mode);
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (rsp_ready) begin
      m_busy = 1'b0;
      m_ops  = m_ops + 16'd1;
    end
  end

  always @(negedge clk) begin : monitor
    int w;
    logic [NR-1:0] er;
    if (mon_en) begin
      w  = winner(req_valid, m_last);
      er = '0;
      if (!rst && !m_busy && w >= 0) er[w] = 1'b1;
      check("mon_req_ready", req_ready, er);
      check("mon_ready_onehot", ($countones(req_ready) <= 1), 1);
      check("mon_rsp_valid", rsp_valid, (m_busy && m_age == 2));
      check("mon_busy", busy, m_busy);
      check("mon_ops_done", ops_done, m_ops);
      check("mon_alu_op0", alu_op0, m_a0);
      check("mon_alu_op1", alu_op1, m_a1);
      check("mon_alu_mode", alu_mode, m_mode);
      if (m_busy && m_age == 2) begin
        check("mon_rsp_id", rsp_id, m_id);
        check("mon_rsp_data", rsp_data, m_data);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic rand_ops();
    for (int j = 0; j < NR*DW/32; j++) begin
      req_op0[j*32 +: 32] = $urandom;
      req_op1[j*32 +: 32] = $urandom;
    end
    req_mode = NR*2'($urandom);
  endtask

  task automatic run_one(input int id);
    req_valid = NR'(1) << id;
    rsp_ready = 1'b1;
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic [1:0]    mode;
    logic [7:0]    a;
    logic [7:0]    b;
    int            exp_id;
    logic [7:0]    exp_byte;
  } vec_t;

  vec_t vec[8];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int got;
    int order[6];
    logic [IW-1:0]  held_id;
    logic [DW-1:0]  held_data;
    logic [DW-1:0]  bp_exp;

    vec[0] = '{4'b0001, 2'b00, 8'hFF, 8'h01, 0, 8'h00};
    vec[1] = '{4'b0010, 2'b01, 8'hF0, 8'h3C, 1, 8'h30};
    vec[2] = '{4'b0100, 2'b10, 8'hF0, 8'h3C, 2, 8'hFC};
    vec[3] = '{4'b1000, 2'b11, 8'hF0, 8'h3C, 3, 8'hCC};
    vec[4] = '{4'b1111, 2'b00, 8'h10, 8'h25, 0, 8'h35};
    vec[5] = '{4'b1010, 2'b11, 8'hAA, 8'h0F, 1, 8'hA5};
    vec[6] = '{4'b1001, 2'b01, 8'h5A, 8'hFF, 3, 8'h5A};
    vec[7] = '{4'b0101, 2'b10, 8'h81, 8'h18, 0, 8'h99};

    req_valid = '0; req_op0 = '0; req_op1 = '0; req_mode = '0; rsp_ready = 1'b0;
    #1;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ops_done", ops_done, 0);
    check("rst_alu_op0", alu_op0, 0);
    check("rst_alu_mode", alu_mode, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    cycle();

    // Table-driven single transactions
    for (int i = 0; i < 8; i++) begin
      req_valid = vec[i].valid;
      for (int r = 0; r < NR; r++) begin
        req_op0[r*DW +: DW] = {(DW/8){vec[i].a}};
        req_op1[r*DW +: DW] = {(DW/8){vec[i].b}};
        req_mode[2*r +: 2]  = vec[i].mode;
      end
      @(negedge clk);
      check("vec_grant", req_ready, NR'(1) << vec[i].exp_id);
      cycle();
      req_valid = '0;
      @(negedge clk);
      check("vec_exec_no_rsp", rsp_valid, 0);
      cycle();
      @(negedge clk);
      check("vec_rsp_valid", rsp_valid, 1);
      check("vec_rsp_id", rsp_id, vec[i].exp_id);
      check("vec_rsp_data", rsp_data, {(DW/8){vec[i].exp_byte}});
      rsp_ready = 1'b1;
      cycle();
      rsp_ready = 1'b0;
      @(negedge clk);
      check("vec_rsp_cleared", rsp_valid, 0);
      check("vec_ops_done", ops_done, i + 1);
      cycle();
    end

    // Fairness: all requesters continuously valid
    reset_dut();
    rand_ops();
    req_valid = '1;
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int b = 0; b < NR; b++) if (req_ready[b]) order[got] = b;
        got++;
      end
      cycle();
    end
    req_valid = '0;
    check("fair_grant_count", got, 6);
    for (int k = 0; k < 6; k++) check("fair_order", order[k], k % NR);
    cycle();
    cycle();
    cycle();
    rsp_ready = 1'b0;
    @(negedge clk);
    check("fair_ops_done", ops_done, 6);
    cycle();

    // Back-pressure: response held for 5 cycles while others keep requesting
    rand_ops();
    req_mode[2*2 +: 2] = 2'b10;
    bp_exp = req_op0[2*DW +: DW] | req_op1[2*DW +: DW];
    req_valid = 4'b0100;
    @(negedge clk);
    check("bp_grant", req_ready, 4'b0100);
    cycle();
    req_valid = '1;
    cycle();
    held_id = rsp_id;
    held_data = rsp_data;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_id", rsp_id, 2);
      check("bp_rsp_data", rsp_data, bp_exp);
      check("bp_stable_data", rsp_data, held_data);
      check("bp_stable_id", rsp_id, held_id);
      check("bp_req_ready", req_ready, 0);
      cycle();
    end
    rsp_ready = 1'b1;
    cycle();
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_released", rsp_valid, 0);
    check("bp_ops_done", ops_done, 7);
    cycle();
    cycle();
    @(negedge clk);
    check("bp_single_rsp", rsp_valid, 0);
    cycle();

    // Reset in EXEC aborts the op
    rand_ops();
    req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    rst = 1'b1;
    #1;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_ops_done", ops_done, 0);
    check("abort_alu_op0", alu_op0, 0);
    check("abort_alu_op1", alu_op1, 0);
    check("abort_alu_mode", alu_mode, 0);
    cycle();
    rst = 1'b0;
    cycle();
    @(negedge clk);
    check("abort_no_rsp", rsp_valid, 0);
    req_valid = 4'b0100;
    #1;
    check("abort_then_req2", req_ready, 4'b0100);
    cycle();
    req_valid = '0;
    rsp_ready = 1'b1;
    cycle();
    cycle();
    rsp_ready = 1'b0;
    @(negedge clk);
    check("abort_ops_after", ops_done, 1);
    cycle();

    // Randomized traffic checked by the monitor
    for (int c = 0; c < 600; c++) begin
      rand_ops();
      req_valid = NR'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) cycle();
    rsp_ready = 1'b0;

    // Counter wrap at 0xFFFF -> 0
    force dut.ops_done = 16'hFFFE;
    m_ops = 16'hFFFE;
    cycle();
    release dut.ops_done;
    @(negedge clk);
    check("wrap_preload", ops_done, 16'hFFFE);
    cycle();
    run_one(1);
    @(negedge clk);
    check("wrap_ffff", ops_done, 16'hFFFF);
    cycle();
    run_one(3);
    @(negedge clk);
    check("wrap_zero", ops_done, 16'h0000);
    cycle();

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
